// File: rtl/dmem_responder_if.sv
// Request/response bus between a memory initiator and dmem_responder.
// The initiator holds the request fields stable until it sees mem_ready.
interface dmem_responder_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_error;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata, mem_error
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata, mem_error
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory responder with configurable response latency.
// Define DMEM_RANGE_CHECK_EN to flag out-of-range accesses instead of wrapping.
module dmem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic              oob;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              oob_c;
  logic              unused_addr_c;

`ifdef DMEM_RANGE_CHECK_EN
  assign oob_c = |bus.mem_addr[31:IDX_W+2];
`else
  assign oob_c = 1'b0;
`endif

  // Byte offset and (when wrapping) high address bits do not select a word.
  assign unused_addr_c = ^{bus.mem_addr[31:IDX_W+2], bus.mem_addr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    ready_d = 1'b0;
    error_d = 1'b0;
    rdata_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.mem_valid) begin
          req_d.oob   = oob_c;
          req_d.idx   = bus.mem_addr[IDX_W+1:2];
          req_d.wdata = bus.mem_wdata;
          req_d.wstrb = bus.mem_wstrb;
          cnt_d       = CNT_W'(WAIT_CYCLES);
          state_d     = (WAIT_CYCLES != 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Response word is captured before this access's own write lands.
    if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
      ready_d = 1'b1;
      error_d = req_d.oob;
      rdata_d = req_d.oob ? '0 : mem[req_d.idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      error_q <= error_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately not reset; reset forces IDLE so no write can fire.
  always_ff @(posedge clk) begin
    if ((state_q == ST_RESP) && !req_q.oob) begin
      for (int i = 0; i < int'(STRB_W); i++) begin
        if (req_q.wstrb[i]) mem[req_q.idx][8*i +: 8] <= req_q.wdata[8*i +: 8];
      end
    end
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
`ifdef DMEM_RANGE_CHECK_EN
  assign bus.mem_error = error_q;
`else
  assign bus.mem_error = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with no wait states, one with three.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder_if if0 ();
  dmem_responder_if if3 ();

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ws);
    if (sel) begin
      if3.mem_valid = v; if3.mem_addr = a; if3.mem_wdata = wd; if3.mem_wstrb = ws;
    end else begin
      if0.mem_valid = v; if0.mem_addr = a; if0.mem_wdata = wd; if0.mem_wstrb = ws;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? if3.mem_ready : if0.mem_ready;
  endfunction

  function automatic logic [31:0] rdat(input bit sel);
    return sel ? if3.mem_rdata : if0.mem_rdata;
  endfunction

  function automatic logic rerr(input bit sel);
    return sel ? if3.mem_error : if0.mem_error;
  endfunction

  // Full access from IDLE; lat counts edges from the accepting edge to mem_ready (0 = timeout).
  task automatic access(input bit sel, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, output logic [31:0] rd, output logic err,
                        output int lat);
    bit seen = 1'b0;
    lat = 0; rd = '0; err = 1'b0;
    @(negedge clk);
    drive(sel, 1'b1, a, wd, ws);
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (rdy(sel)) begin
        seen = 1'b1; lat = k; rd = rdat(sel); err = rerr(sel);
      end
    end
    drive(sel, 1'b0, '0, '0, '0);
    @(posedge clk); #1;
    check_eq("ready_pulse_end", 32'(rdy(sel)), 32'd0);
    check_eq("rdata_idle_zero", rdat(sel), 32'd0);
  endtask

  logic [31:0] rd, pat, rd_b2b;
  logic        err;
  int          lat;

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready0", 32'(if0.mem_ready), 32'd0);
    check_eq("rst_rdata0", if0.mem_rdata, 32'd0);
    check_eq("rst_error0", 32'(if0.mem_error), 32'd0);
    check_eq("rst_ready3", 32'(if3.mem_ready), 32'd0);
    @(negedge clk) rst = 1'b1;

    // Full-word write then read back, zero wait states
    access(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, rd, err, lat);
    check_eq("w10_lat", 32'(lat), 32'd1);
    check_eq("w10_err", 32'(err), 32'd0);
    access(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat);
    check_eq("r10_lat", 32'(lat), 32'd1);
    check_eq("r10_data", rd, 32'hDEADBEEF);

    // Single byte lane write; own rdata is the pre-write word
    access(1'b0, 32'h12, 32'h00AA0000, 4'h4, rd, err, lat);
    check_eq("wstrb_old_data", rd, 32'hDEADBEEF);
    access(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat);
    check_eq("wstrb_merge", rd, 32'hDEAABEEF);
    access(1'b0, 32'h13, 32'h0, 4'h0, rd, err, lat);
    check_eq("addr_lsb_ignored", rd, 32'hDEAABEEF);

    // Three wait states, then back-to-back with mem_valid held
    access(1'b1, 32'h10, 32'h12345678, 4'hF, rd, err, lat);
    check_eq("w3_lat", 32'(lat), 32'd4);
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h10, 32'h0, 4'h0);
    pat = '0; rd_b2b = '0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      pat[k] = if3.mem_ready;
      if (k == 4) rd_b2b = if3.mem_rdata;
    end
    drive(1'b1, 1'b0, '0, '0, '0);
    check_eq("b2b_ready_pattern", pat, 32'h0000_0210);
    check_eq("b2b_rdata", rd_b2b, 32'h12345678);
    repeat (2) @(posedge clk);

    // mem_valid dropped right after acceptance; access still completes
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h24, 32'h0F0F0F0F, 4'hF);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, '0, '0, '0);
    lat = 0;
    for (int k = 2; k <= 20 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (if3.mem_ready) lat = k;
    end
    check_eq("vdrop_lat", 32'(lat), 32'd4);
    @(posedge clk);
    access(1'b1, 32'h24, 32'h0, 4'h0, rd, err, lat);
    check_eq("vdrop_written", rd, 32'h0F0F0F0F);

    // Reset during WAIT discards a pending write
    access(1'b1, 32'h20, 32'h11111111, 4'hF, rd, err, lat);
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h20, 32'h22222222, 4'hF);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, '0, '0, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("rst_wait_ready", 32'(if3.mem_ready), 32'd0);
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    access(1'b1, 32'h20, 32'h0, 4'h0, rd, err, lat);
    check_eq("rst_wait_nowrite", rd, 32'h11111111);

    // Reset while mem_ready is high clears outputs at once and blocks the write
    access(1'b0, 32'h30, 32'hAAAA5555, 4'hF, rd, err, lat);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h30, 32'h5A5A5A5A, 4'hF);
    @(posedge clk); #1;
    check_eq("rst_resp_pre_ready", 32'(if0.mem_ready), 32'd1);
    drive(1'b0, 1'b0, '0, '0, '0);
    rst = 1'b0;
    #1;
    check_eq("rst_resp_ready", 32'(if0.mem_ready), 32'd0);
    check_eq("rst_resp_rdata", if0.mem_rdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    access(1'b0, 32'h30, 32'h0, 4'h0, rd, err, lat);
    check_eq("rst_resp_nowrite", rd, 32'hAAAA5555);

    // Address beyond DEPTH*4
    access(1'b0, 32'h0, 32'h0BADC0DE, 4'hF, rd, err, lat);
    access(1'b0, 32'h1000, 32'hCAFEF00D, 4'hF, rd, err, lat);
    check_eq("oob_lat", 32'(lat), 32'd1);
`ifdef DMEM_RANGE_CHECK_EN
    check_eq("oob_error", 32'(err), 32'd1);
    check_eq("oob_rdata", rd, 32'd0);
    access(1'b0, 32'h0, 32'h0, 4'h0, rd, err, lat);
    check_eq("oob_no_write", rd, 32'h0BADC0DE);
`else
    check_eq("wrap_error", 32'(err), 32'd0);
    check_eq("wrap_rdata", rd, 32'h0BADC0DE);
    access(1'b0, 32'h0, 32'h0, 4'h0, rd, err, lat);
    check_eq("wrap_written", rd, 32'hCAFEF00D);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, failures so far %0d", n_fail);
    $fatal(1);
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning memory size in 32-bit words (power of two, >=4).
REQ-002 SHALL have parameter WAIT_CYCLES, default 0, meaning extra latency cycles inserted before each response (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mem_valid  input  1  request present; initiator holds it and all request fields stable until mem_ready.
REQ-006 SHALL have port mem_addr  input  32  byte address.
REQ-007 SHALL have port mem_wdata  input  32  write data, lane-aligned.
REQ-008 SHALL have port mem_wstrb  input  4  byte write enables; 0 means read.
REQ-009 SHALL have port mem_ready  output  1  one-cycle response pulse.
REQ-010 SHALL have port mem_rdata  output  32  read word, valid while mem_ready=1.
REQ-011 SHALL have port mem_error  output  1  access fault, valid while mem_ready=1.

Function
REQ-012 SHALL implement states IDLE, WAIT and RESP.
REQ-013 IDLE with mem_valid=1 SHALL latch addr, wdata and wstrb, load the wait counter with WAIT_CYCLES, and go to WAIT if WAIT_CYCLES>0, else RESP.
REQ-014 WAIT SHALL decrement the counter each cycle and go to RESP on the cycle the counter reaches 1.
REQ-015 RESP SHALL assert mem_ready for exactly one cycle, then return to IDLE.
REQ-016 Latency SHALL be WAIT_CYCLES+1 cycles from the accepting IDLE edge to mem_ready high.
REQ-017 Word index SHALL be latched addr[log2(DEPTH)+1:2]; addr[1:0] SHALL be ignored.
REQ-018 In RESP, mem_rdata SHALL be the addressed word as it was before this access's write (read-before-write).
REQ-019 In RESP, each byte lane i with wstrb[i]=1 SHALL be written on the RESP clock edge; other lanes SHALL be unchanged.
REQ-020 The latched request SHALL complete even if mem_valid drops during WAIT/RESP; new mem_valid SHALL be ignored outside IDLE.
REQ-021 Back-to-back: mem_valid high in the IDLE cycle after RESP SHALL start a new access; maximum throughput SHALL be one access per WAIT_CYCLES+2 cycles.
REQ-022 mem_rdata and mem_error SHALL be 0 whenever mem_ready=0.
REQ-023 Memory contents SHALL NOT be reset.

Reset
REQ-024 Asserting rst=0 SHALL immediately force state IDLE, mem_ready=0, mem_rdata=0, mem_error=0 and counter=0.
REQ-025 Reset mid-access SHALL discard the pending request; no write SHALL occur.
REQ-026 The first access SHALL be accepted no earlier than the first rising edge after rst returns to 1.

Configuration
REQ-027 Macro DMEM_RANGE_CHECK_EN SHALL compile the range check in or out.
REQ-028 With DMEM_RANGE_CHECK_EN defined, an access with latched addr >= DEPTH*4 SHALL still respond with normal latency, with mem_error=1, mem_rdata=0 and no write.
REQ-029 Without DMEM_RANGE_CHECK_EN, out-of-range addresses SHALL wrap modulo DEPTH*4, and mem_error SHALL be tied 0.

Verification
REQ-030 WAIT_CYCLES=0: write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF -> ready 1 cycle after accept; a following read of 0x10 -> rdata 0xDEADBEEF.
REQ-031 Byte strobe: after REQ-030, write addr 0x12, wdata 0x00AA0000, wstrb 0x4 -> a read of 0x10 returns 0xDEAABEEF; the write's own rdata is 0xDEADBEEF.
REQ-032 WAIT_CYCLES=3: read -> mem_ready rises exactly 4 cycles after accept and is high for exactly 1 cycle; mem_valid held high -> next accept in the cycle after RESP.
REQ-033 Reset during WAIT of a write to 0x20 (old 0x11111111) -> mem_ready=0 immediately; a read of 0x20 after reset returns 0x11111111.
REQ-034 DMEM_RANGE_CHECK_EN, DEPTH=1024: write 0x1000 -> mem_error=1, rdata 0; a read of 0x0 is unchanged. Without the macro: a write to 0x1000 is readable at 0x0 and mem_error=0.
